// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard unit with a multi-cycle (MUL/DIV) E-stage sequencer.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   Rs1D..RdW                      register indices for the D/E/M/W stages
//   RegWriteM/W, ResultSrcE0       write-back enables, load in E
//   McStartE, PCSrcE               multi-cycle op in E, taken branch in E
//   MemReqM, MemReadyM             data-memory handshake in M
//   StallF/D/E/M, FlushD/E/M/W     stage-register hold / bubble controls
//   ForwardAE/BE                   operand bypass selects (00 RF, 01 W, 10 M)
//   McBusy, StallCount             sequencer busy flag, saturating fetch-stall counter
module hazard_ctrl_mc #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              McStartE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int unsigned MC_CW = $clog2(MC_LAT);
  localparam logic [MC_CW-1:0] MC_INIT = MC_CW'(MC_LAT - 2);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t           state;
  logic [MC_CW-1:0] mcCnt;
  logic             memStall;
  logic             lwStall;
  logic             mcStall;

  // Operand bypass: the younger M result wins over W; x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      if (Rs1E != '0 && Rs1E == RdM && RegWriteM)      ForwardAE = 2'b10;
      else if (Rs1E != '0 && Rs1E == RdW && RegWriteW) ForwardAE = 2'b01;
      if (Rs2E != '0 && Rs2E == RdM && RegWriteM)      ForwardBE = 2'b10;
      else if (Rs2E != '0 && Rs2E == RdW && RegWriteW) ForwardBE = 2'b01;
    end
  end

  // Hazard sources; in IDLE a start request stalls even while memory holds the FSM.
  always_comb begin
    memStall = MemReqM & ~MemReadyM;
    lwStall  = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    mcStall  = (state == IDLE) ? McStartE : (mcCnt != '0);
  end

  // Prioritised stall/flush decode.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (memStall) begin
      // E is frozen, so a taken branch waits until memory releases.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mcStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      // Wrong-path D instruction is squashed, so a load-use stall on it is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lwStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Multi-cycle sequencer and saturating stall counter; memory stalls freeze the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mcCnt      <= '0;
      StallCount <= '0;
    end else begin
      if (StallF && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
      if (!memStall) begin
        case (state)
          IDLE: begin
            if (McStartE) begin
              state <= MC_BUSY;
              mcCnt <= MC_INIT;
            end
          end
          MC_BUSY: begin
            if (mcCnt != '0) mcCnt <= mcCnt - MC_CW'(1);
            else             state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign McBusy = (state == MC_BUSY);

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: a driver issues stimulus and queues the
// expected response from a cycle-count reference model; a monitor checks each cycle.
module tb_hazard_ctrl_mc;

  localparam int unsigned AW   = 5;
  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, ResultSrcE0, McStartE, PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          McBusy;
  logic [CW-1:0] StallCount;

  hazard_ctrl_mc #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .McStartE(McStartE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McBusy(McBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: an op occupies E for LAT advancing cycles; opAge counts those already done.
  bit mBusy  = 1'b0;
  int opAge  = 0;
  int mCount = 0;

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (rst) return 2'b00;
    if (rs != 0 && rs == RdM && RegWriteM) return 2'b10;
    if (rs != 0 && rs == RdW && RegWriteW) return 2'b01;
    return 2'b00;
  endfunction

  // Queue the expected response for the current inputs, then advance the model one edge.
  task automatic step(input string tag);
    exp_t e;
    bit memS, lwS, mcS;
    memS = MemReqM && !MemReadyM;
    lwS  = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    mcS  = mBusy ? (opAge + 1 < LAT) : McStartE;
    e.tag  = tag;
    e.fa   = fwd(Rs1E);
    e.fb   = fwd(Rs2E);
    e.busy = mBusy;
    e.cnt  = CW'(mCount);
    if (rst)          e.ctl = 8'b0000_1111;
    else if (memS)    e.ctl = 8'b1111_0001;
    else if (mcS)     e.ctl = 8'b1110_0010;
    else if (PCSrcE)  e.ctl = 8'b0000_1100;
    else if (lwS)     e.ctl = 8'b1100_0100;
    else              e.ctl = 8'b0000_0000;
    sbq.push_back(e);
    if (rst) begin
      mBusy = 1'b0; opAge = 0; mCount = 0;
    end else begin
      if (e.ctl[7] && mCount < CMAX) mCount++;
      if (!memS) begin
        if (!mBusy) begin
          if (McStartE) begin mBusy = 1'b1; opAge = 1; end
        end else begin
          opAge++;
          if (opAge == LAT) begin mBusy = 1'b0; opAge = 0; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, McStartE, PCSrcE, MemReqM} = '0;
    MemReadyM = 1'b1;
  endtask

  task automatic chk(input string tag, input string what, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", tag, what, act, req, $time);
    end
  endtask

  // Monitor: every cycle presents a response; compare it against the oldest queued expectation.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.tag, "ctl", int'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}), int'(e.ctl));
      chk(e.tag, "fwdA", int'(ForwardAE), int'(e.fa));
      chk(e.tag, "fwdB", int'(ForwardBE), int'(e.fb));
      chk(e.tag, "busy", int'(McBusy), int'(e.busy));
      chk(e.tag, "count", int'(StallCount), int'(e.cnt));
    end
  end

  initial begin
    quiet();
    rst = 1'b1;
    @(posedge clk); #1;
    step("reset");
    rst = 1'b0;
    step("idle");

    // Forwarding: M beats W; x0 never forwards.
    Rs1E = 3; RdM = 3; RegWriteM = 1; RdW = 3; RegWriteW = 1;
    step("fwdMoverW");
    Rs1E = 0; Rs2E = 0; RdW = 0; RdM = 7;
    step("fwdX0");
    Rs1E = 4; Rs2E = 6; RdM = 6; RdW = 4;
    step("fwdMix");
    quiet();

    // Load-use stall, then the same with RdE = x0.
    ResultSrcE0 = 1; RdE = 5; Rs2D = 5;
    step("lwStall");
    RdE = 0; Rs2D = 0;
    step("lwX0");
    quiet();

    // Multi-cycle op with McStartE held for four cycles.
    McStartE = 1;
    repeat (4) step("mcHeld");
    McStartE = 0;
    step("mcDone");
    repeat (2) step("mcIdle");

    // Memory stall arriving while the sequencer is on its last stall cycle.
    rst = 1; step("rstPreMem"); rst = 0;
    McStartE = 1; step("mcStart2");
    McStartE = 0; step("mcBusy2");
    MemReqM = 1; MemReadyM = 0;
    repeat (2) step("memHold");
    MemReadyM = 1;
    repeat (3) step("memRelease");
    quiet();

    // Branch beats load-use; branch deferred under memory stall.
    PCSrcE = 1; ResultSrcE0 = 1; RdE = 2; Rs1D = 2;
    step("pcOverLw");
    ResultSrcE0 = 0; MemReqM = 1; MemReadyM = 0;
    repeat (2) step("pcUnderMem");
    MemReadyM = 1;
    step("pcAfterMem");
    quiet();

    // Reset mid-op, then a long load-use stall to saturate the counter.
    McStartE = 1; step("mcForRst");
    McStartE = 0; step("mcForRst2");
    rst = 1; step("rstMidOp"); rst = 0;
    step("postRst");
    ResultSrcE0 = 1; RdE = 9; Rs1D = 9;
    repeat (20) step("saturate");
    quiet();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      Rs1D        = AW'($urandom_range(0, 3));
      Rs2D        = AW'($urandom_range(0, 3));
      Rs1E        = AW'($urandom_range(0, 3));
      Rs2E        = AW'($urandom_range(0, 3));
      RdE         = AW'($urandom_range(0, 3));
      RdM         = AW'($urandom_range(0, 3));
      RdW         = AW'($urandom_range(0, 3));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 99) < 30);
      McStartE    = ($urandom_range(0, 99) < 15);
      PCSrcE      = ($urandom_range(0, 99) < 15);
      MemReqM     = ($urandom_range(0, 99) < 30);
      MemReadyM   = 1'($urandom_range(0, 1));
      step("random");
    end
    quiet();

    // Drain the scoreboard within a bounded number of cycles.
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
